// File: rtl/slt_serial_unit.sv
// Bit-serial lt/eq/gt magnitude comparator with an SLT-formatted result.
// Walks the operands LSB to MSB, one bit per clock, behind a start/done handshake.
module slt_serial_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_lt,
   output logic             o_eq,
   output logic             o_gt,
   output logic [WIDTH-1:0] o_rd
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;

   logic [WIDTH-1:0] r_rs;
   logic [WIDTH-1:0] r_rt;
   logic             r_signed;
   logic [IW-1:0]    r_idx;
   logic             r_wlt;
   logic             r_weq;
   logic             r_wgt;

   logic             r_busy;
   logic             r_done;
   logic             r_lt;
   logic             r_eq;
   logic             r_gt;
   logic [WIDTH-1:0] r_rd;

   logic             w_last;
   logic             w_a;
   logic             w_b;
   logic             w_al;
   logic             w_bl;
   logic             w_same;
   logic             w_wlt_nxt;
   logic             w_weq_nxt;
   logic             w_wgt_nxt;

   assign w_last = (r_idx == LAST_IDX);

   // One slice of the cascaded comparator. In signed mode the sign bit's
   // ordering is inverted: a set sign bit marks the smaller operand.
   always_comb begin
      w_a       = r_rs[r_idx];
      w_b       = r_rt[r_idx];
      w_same    = ~(w_a ^ w_b);
      w_al      = (r_signed && w_last) ? w_b : w_a;
      w_bl      = (r_signed && w_last) ? w_a : w_b;
      w_wlt_nxt = (w_bl & ~w_al) | (w_same & r_wlt);
      w_weq_nxt = r_weq & w_same;
      w_wgt_nxt = (w_al & ~w_bl) | (w_same & r_wgt);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
            end
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_accept    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rs     <= '0;
         r_rt     <= '0;
         r_signed <= 1'b0;
         r_idx    <= '0;
         r_wlt    <= 1'b0;
         r_weq    <= 1'b0;
         r_wgt    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_lt     <= 1'b0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_rd     <= '0;
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= (r_state == S_RUN) && w_last;
         if (w_accept) begin
            r_rs     <= i_rs;
            r_rt     <= i_rt;
            r_signed <= i_is_signed;
            r_idx    <= '0;
            r_wlt    <= 1'b0;
            r_weq    <= 1'b1;
            r_wgt    <= 1'b0;
         end else if (r_state == S_RUN) begin
            r_idx <= r_idx + IW'(1);
            r_wlt <= w_wlt_nxt;
            r_weq <= w_weq_nxt;
            r_wgt <= w_wgt_nxt;
            // Results only move on completion and otherwise hold.
            if (w_last) begin
               r_lt <= w_wlt_nxt;
               r_eq <= w_weq_nxt;
               r_gt <= w_wgt_nxt;
               r_rd <= {{(WIDTH-1){1'b0}}, w_wlt_nxt};
            end
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_lt   = r_lt;
   assign o_eq   = r_eq;
   assign o_gt   = r_gt;
   assign o_rd   = r_rd;

endmodule
